// File: rtl/command_frame_controller_pkg.sv
// Shared opcodes, operand addresses and FSM state encoding for the command frame controller.
package command_frame_controller_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPERAND_A_ADDR = 0;
    localparam int unsigned OPERAND_B_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        OP_FUNC,
        FUNC_ONLY,
        ALU_WAIT
    } state_t;

endpackage

// File: rtl/command_frame_controller_response_fifo.sv
// Synchronous response FIFO; full/empty/free_count are registered from the next-cycle count.
module response_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          push_data,
    input  logic                           pop,
    output logic [DATA_WIDTH-1:0]          head_data_c,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     free_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_n;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign head_data_c = mem[rd_ptr];

    always_comb begin
        count_n = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            free_count <= CW'(DEPTH);
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count      <= count_n;
            free_count <= CW'(DEPTH) - count_n;
            full       <= (count_n == CW'(DEPTH));
            empty      <= (count_n == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/command_frame_controller.sv
// Decodes UART command frames into register-file / ALU strobes and queues response bytes for TX.
module command_frame_controller
    import command_frame_controller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RF_DEPTH       = 16,
    parameter int unsigned RESULT_BYTES   = 2,
    parameter int unsigned TX_FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 rx_data_valid,
    input  logic [DATA_WIDTH-1:0]                rx_data,
    input  logic                                 tx_busy,
    output logic                                 tx_data_valid,
    output logic [DATA_WIDTH-1:0]                tx_data,
    output logic [$clog2(RF_DEPTH)-1:0]          rf_address,
    output logic                                 rf_write_enable,
    output logic [DATA_WIDTH-1:0]                rf_write_data,
    output logic                                 rf_read_enable,
    input  logic                                 rf_read_data_valid,
    input  logic [DATA_WIDTH-1:0]                rf_read_data,
    output logic [3:0]                           alu_function,
    output logic                                 alu_enable,
    output logic                                 alu_clk_enable,
    input  logic                                 alu_result_valid,
    input  logic [RESULT_BYTES*DATA_WIDTH-1:0]   alu_result,
    output logic                                 frame_error
);

    localparam int unsigned AW  = $clog2(RF_DEPTH);
    localparam int unsigned RW  = RESULT_BYTES * DATA_WIDTH;
    localparam int unsigned FCW = $clog2(TX_FIFO_DEPTH + 1);
    localparam int unsigned BCW = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
    localparam int unsigned TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [RW-1:0]         result_q, result_d;
    logic [BCW-1:0]        cnt_q, cnt_d;
    logic                  have_q, have_d;
    logic                  await_q, await_d;
    logic [AW-1:0]         addr_d;
    logic [DATA_WIDTH-1:0] wd_d, tx_data_d;
    logic [3:0]            fn_d;
    logic                  we_d, re_d, alu_en_d, clk_en_d, fe_d, tx_valid_d;
    logic                  push_c, pop_c, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] push_data_c, head_data_c;
    logic [FCW-1:0]        free_count;

    response_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TX_FIFO_DEPTH)
    ) u_response_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push_c && !fifo_full),
        .push_data   (push_data_c),
        .pop         (pop_c),
        .head_data_c (head_data_c),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .free_count  (free_count)
    );

    // Frame decode, timeout and response serialisation.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        have_d      = have_q;
        addr_d      = rf_address;
        wd_d        = rf_write_data;
        fn_d        = alu_function;
        clk_en_d    = alu_clk_enable;
        we_d        = 1'b0;
        re_d        = 1'b0;
        alu_en_d    = 1'b0;
        fe_d        = 1'b0;
        push_c      = 1'b0;
        push_data_c = '0;

        if (state_q inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUNC, FUNC_ONLY}) begin
            if (rx_data_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                fe_d    = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_data_valid) begin
                    if (free_count < FCW'(RESULT_BYTES)) begin
                        fe_d = 1'b1;
                    end else begin
                        case (rx_data)
                            DATA_WIDTH'(CMD_RF_WR):   state_d = WR_ADDR;
                            DATA_WIDTH'(CMD_RF_RD):   state_d = RD_ADDR;
                            DATA_WIDTH'(CMD_ALU_OP):  state_d = OP_A;
                            DATA_WIDTH'(CMD_ALU_NOP): state_d = FUNC_ONLY;
                            default:                  fe_d    = 1'b1;
                        endcase
                    end
                end
            end
            WR_ADDR: if (rx_data_valid) begin
                addr_d  = rx_data[AW-1:0];
                state_d = WR_DATA;
            end
            WR_DATA: if (rx_data_valid) begin
                wd_d    = rx_data;
                we_d    = 1'b1;
                state_d = IDLE;
            end
            RD_ADDR: if (rx_data_valid) begin
                addr_d  = rx_data[AW-1:0];
                re_d    = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (rf_read_data_valid) begin
                push_c      = 1'b1;
                push_data_c = rf_read_data;
                state_d     = IDLE;
            end
            OP_A: if (rx_data_valid) begin
                addr_d  = AW'(OPERAND_A_ADDR);
                wd_d    = rx_data;
                we_d    = 1'b1;
                state_d = OP_B;
            end
            OP_B: if (rx_data_valid) begin
                addr_d  = AW'(OPERAND_B_ADDR);
                wd_d    = rx_data;
                we_d    = 1'b1;
                state_d = OP_FUNC;
            end
            OP_FUNC, FUNC_ONLY: if (rx_data_valid) begin
                fn_d     = rx_data[3:0];
                alu_en_d = 1'b1;
                clk_en_d = 1'b1;
                have_d   = 1'b0;
                cnt_d    = '0;
                state_d  = ALU_WAIT;
            end
            ALU_WAIT: begin
                // Captured result drains LSB-first, one byte per cycle.
                if (have_q) begin
                    clk_en_d    = 1'b0;
                    push_c      = 1'b1;
                    push_data_c = result_q[DATA_WIDTH-1:0];
                    result_d    = result_q >> DATA_WIDTH;
                    cnt_d       = cnt_q + BCW'(1);
                    if (cnt_q == BCW'(RESULT_BYTES - 1)) begin
                        have_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (alu_result_valid) begin
                    result_d = alu_result;
                    have_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TX drain: one byte per transmitter busy episode.
    always_comb begin
        pop_c      = !fifo_empty && !tx_busy && !await_q;
        tx_valid_d = pop_c;
        tx_data_d  = pop_c ? head_data_c : tx_data;
        await_d    = pop_c ? 1'b1 : (tx_busy ? 1'b0 : await_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            tmo_q           <= '0;
            result_q        <= '0;
            cnt_q           <= '0;
            have_q          <= 1'b0;
            await_q         <= 1'b0;
            rf_address      <= '0;
            rf_write_enable <= 1'b0;
            rf_write_data   <= '0;
            rf_read_enable  <= 1'b0;
            alu_function    <= '0;
            alu_enable      <= 1'b0;
            alu_clk_enable  <= 1'b0;
            frame_error     <= 1'b0;
            tx_data_valid   <= 1'b0;
            tx_data         <= '0;
        end else begin
            state_q         <= state_d;
            tmo_q           <= tmo_d;
            result_q        <= result_d;
            cnt_q           <= cnt_d;
            have_q          <= have_d;
            await_q         <= await_d;
            rf_address      <= addr_d;
            rf_write_enable <= we_d;
            rf_write_data   <= wd_d;
            rf_read_enable  <= re_d;
            alu_function    <= fn_d;
            alu_enable      <= alu_en_d;
            alu_clk_enable  <= clk_en_d;
            frame_error     <= fe_d;
            tx_data_valid   <= tx_valid_d;
            tx_data         <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_command_frame_controller.sv
// Scoreboard bench: stimulus queues expected strobes/bytes, negedge monitors pop and compare.
module tb_command_frame_controller;

    localparam int unsigned TMO = 1024;
    localparam logic [7:0] EV_WR = 8'd1, EV_RD = 8'd2, EV_ALU = 8'd3, EV_FE = 8'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        rx_data_valid, tx_busy, tx_data_valid, rf_write_enable, rf_read_enable;
    logic        rf_read_data_valid, alu_enable, alu_clk_enable, alu_result_valid, frame_error;
    logic [7:0]  rx_data, tx_data, rf_write_data, rf_read_data;
    logic [3:0]  rf_address, alu_function;
    logic [15:0] alu_result;

    logic        rx_data_valid2, tx_busy2, tx_data_valid2, rf_write_enable2, rf_read_enable2;
    logic        rf_read_data_valid2, alu_enable2, alu_clk_enable2, alu_result_valid2, frame_error2;
    logic [7:0]  rx_data2, tx_data2, rf_write_data2, rf_read_data2;
    logic [3:0]  rf_address2, alu_function2;
    logic [23:0] alu_result2;

    int          vectors = 0, miscompares = 0;
    logic [31:0] ev_q[$];
    logic [7:0]  tx_q[$], tx2_q[$];
    logic        hold_busy = 1'b0;
    int          busy_cnt = 0, busy_cnt2 = 0;

    command_frame_controller u_dut (
        .clk(clk), .reset(reset), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
        .rf_address(rf_address), .rf_write_enable(rf_write_enable), .rf_write_data(rf_write_data),
        .rf_read_enable(rf_read_enable), .rf_read_data_valid(rf_read_data_valid),
        .rf_read_data(rf_read_data), .alu_function(alu_function), .alu_enable(alu_enable),
        .alu_clk_enable(alu_clk_enable), .alu_result_valid(alu_result_valid),
        .alu_result(alu_result), .frame_error(frame_error)
    );

    command_frame_controller #(.RESULT_BYTES(3)) u_dut3 (
        .clk(clk), .reset(reset), .rx_data_valid(rx_data_valid2), .rx_data(rx_data2),
        .tx_busy(tx_busy2), .tx_data_valid(tx_data_valid2), .tx_data(tx_data2),
        .rf_address(rf_address2), .rf_write_enable(rf_write_enable2), .rf_write_data(rf_write_data2),
        .rf_read_enable(rf_read_enable2), .rf_read_data_valid(rf_read_data_valid2),
        .rf_read_data(rf_read_data2), .alu_function(alu_function2), .alu_enable(alu_enable2),
        .alu_clk_enable(alu_clk_enable2), .alu_result_valid(alu_result_valid2),
        .alu_result(alu_result2), .frame_error(frame_error2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_ev(input logic [7:0] k, input logic [7:0] a, input logic [15:0] d);
        return {k, a, d};
    endfunction

    // Strobe monitor for the default instance.
    initial begin
        logic [31:0] act, exp;
        forever begin
            @(negedge clk);
            if (rf_write_enable || rf_read_enable || alu_enable || frame_error) begin
                act = rf_write_enable ? mk_ev(EV_WR, {4'h0, rf_address}, {8'h00, rf_write_data}) :
                      rf_read_enable  ? mk_ev(EV_RD, {4'h0, rf_address}, 16'h0000) :
                      alu_enable      ? mk_ev(EV_ALU, 8'h00, {12'h000, alu_function}) :
                                        mk_ev(EV_FE, 8'h00, 16'h0000);
                exp = (ev_q.size() != 0) ? ev_q.pop_front() : 32'h0;
                check("strobe_event", act, exp);
                if (alu_enable) check("alu_clk_enable", 32'(alu_clk_enable), 32'h1);
            end
        end
    end

    // TX monitors: byte order and one byte per busy episode.
    initial begin
        logic seen = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_data_valid) begin
                check("tx_byte", {23'h0, 1'b1, tx_data},
                      (tx_q.size() != 0) ? {23'h0, 1'b1, tx_q.pop_front()} : 32'h0);
                check("tx_after_busy", 32'(seen), 32'h1);
                seen = 1'b0;
            end
            if (tx_busy) seen = 1'b1;
        end
    end

    initial begin
        logic seen = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_data_valid2) begin
                check("tx3_byte", {23'h0, 1'b1, tx_data2},
                      (tx2_q.size() != 0) ? {23'h0, 1'b1, tx2_q.pop_front()} : 32'h0);
                check("tx3_after_busy", 32'(seen), 32'h1);
                seen = 1'b0;
            end
            if (tx_busy2) seen = 1'b1;
        end
    end

    // Transmitter models: busy for three cycles after each byte.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (busy_cnt != 0) busy_cnt--;
            if (tx_data_valid) busy_cnt = 3;
            tx_busy = hold_busy || (busy_cnt != 0);
        end
    end

    initial begin
        tx_busy2 = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (busy_cnt2 != 0) busy_cnt2--;
            if (tx_data_valid2) busy_cnt2 = 3;
            tx_busy2 = (busy_cnt2 != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send1(input logic [7:0] b);
        @(negedge clk); rx_data = b; rx_data_valid = 1'b1;
        @(negedge clk); rx_data_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge clk); rx_data2 = b; rx_data_valid2 = 1'b1;
        @(negedge clk); rx_data_valid2 = 1'b0;
    endtask

    task automatic rd_resp(input logic [7:0] d);
        for (int i = 0; i < 20; i++) begin
            if (rf_read_enable) break;
            @(negedge clk);
        end
        @(negedge clk); rf_read_data = d; rf_read_data_valid = 1'b1;
        @(negedge clk); rf_read_data_valid = 1'b0;
    endtask

    task automatic alu_resp1(input logic [15:0] r);
        for (int i = 0; i < 20; i++) begin
            if (alu_enable) break;
            @(negedge clk);
        end
        idle(2); alu_result = r; alu_result_valid = 1'b1;
        @(negedge clk); alu_result_valid = 1'b0;
    endtask

    task automatic alu_resp2(input logic [23:0] r);
        for (int i = 0; i < 20; i++) begin
            if (alu_enable2) break;
            @(negedge clk);
        end
        idle(2); alu_result2 = r; alu_result_valid2 = 1'b1;
        @(negedge clk); alu_result_valid2 = 1'b0;
    endtask

    task automatic wait_drain1();
        for (int i = 0; i < 300; i++) begin
            if (tx_q.size() == 0 && !tx_busy) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain2();
        for (int i = 0; i < 300; i++) begin
            if (tx2_q.size() == 0 && !tx_busy2) break;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        rx_data_valid = 1'b0;  rx_data = '0;  rf_read_data_valid = 1'b0;  rf_read_data = '0;
        alu_result_valid = 1'b0;  alu_result = '0;
        rx_data_valid2 = 1'b0; rx_data2 = '0; rf_read_data_valid2 = 1'b0; rf_read_data2 = '0;
        alu_result_valid2 = 1'b0; alu_result2 = '0;
        idle(3);
        check("rst_strobes", {26'h0, tx_data_valid, rf_write_enable, rf_read_enable,
                              alu_enable, alu_clk_enable, frame_error}, 32'h0);
        check("rst_buses", {tx_data, rf_write_data, rf_address, alu_function, 8'h00}, 32'h0);
        check("rst_strobes3", {26'h0, tx_data_valid2, rf_write_enable2, rf_read_enable2,
                               alu_enable2, alu_clk_enable2, frame_error2}, 32'h0);
        reset = 1'b1;
        idle(2);

        // Register write: AA,05,3C.
        ev_q.push_back(mk_ev(EV_WR, 8'h05, 16'h003C));
        send1(8'hAA); send1(8'h05); send1(8'h3C);
        idle(5);

        // Register read: BB,05 returns 3C.
        ev_q.push_back(mk_ev(EV_RD, 8'h05, 16'h0000));
        tx_q.push_back(8'h3C);
        send1(8'hBB); send1(8'h05);
        rd_resp(8'h3C);
        idle(5);

        // ALU with operands: CC,0A,03,00 with result 0x000D.
        ev_q.push_back(mk_ev(EV_WR, 8'h00, 16'h000A));
        ev_q.push_back(mk_ev(EV_WR, 8'h01, 16'h0003));
        ev_q.push_back(mk_ev(EV_ALU, 8'h00, 16'h0000));
        tx_q.push_back(8'h0D); tx_q.push_back(8'h00);
        send1(8'hCC); send1(8'h0A); send1(8'h03); send1(8'h00);
        alu_resp1(16'h000D);
        wait_drain1();

        // Three-byte result instance: DD,02 with 0x123456.
        tx2_q.push_back(8'h56); tx2_q.push_back(8'h34); tx2_q.push_back(8'h12);
        send2(8'hDD); send2(8'h02);
        alu_resp2(24'h123456);
        wait_drain2();

        // Inter-byte timeout aborts the write, then a fresh write goes through.
        ev_q.push_back(mk_ev(EV_FE, 8'h00, 16'h0000));
        send1(8'hAA); send1(8'h05);
        idle(TMO + 10);
        ev_q.push_back(mk_ev(EV_WR, 8'h01, 16'h00FF));
        send1(8'hAA); send1(8'h01); send1(8'hFF);
        idle(5);

        // Unknown opcode.
        ev_q.push_back(mk_ev(EV_FE, 8'h00, 16'h0000));
        send1(8'h77);
        idle(5);

        // Fill FIFO with transmitter held busy, then a read opcode is dropped.
        wait_drain1();
        hold_busy = 1'b1;
        idle(3);
        for (int k = 0; k < 2; k++) begin
            ev_q.push_back(mk_ev(EV_ALU, 8'h00, 16'h0001));
            tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
            send1(8'hDD); send1(8'h01);
            alu_resp1(16'hBEEF);
            idle(6);
        end
        ev_q.push_back(mk_ev(EV_FE, 8'h00, 16'h0000));
        send1(8'hBB);
        idle(5);
        hold_busy = 1'b0;
        wait_drain1();
        idle(10);

        check("events_left", 32'(ev_q.size()), 32'h0);
        check("tx_left", 32'(tx_q.size()), 32'h0);
        check("tx3_left", 32'(tx2_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
